// File: rtl/mult_pkg.sv
// Shared opcodes, FSM state and program-step encodings for the sequential
// shift-add multiplier that drives an external mult instruction unit.
package mult_pkg;

  localparam logic [4:0] OP_MOV_R0 = 5'b00000;
  localparam logic [4:0] OP_MOV_R1 = 5'b00100;
  localparam logic [4:0] OP_MOV_R2 = 5'b01000;
  localparam logic [4:0] OP_TEST   = 5'b00011;
  localparam logic [4:0] OP_ACC    = 5'b11001;
  localparam logic [4:0] OP_SHR    = 5'b00001;
  localparam logic [4:0] OP_SHL    = 5'b00110;

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT_LO, WAIT_HI, NEXT, FIN
  } state_t;

  typedef enum logic [2:0] {
    ST_MOV_R0, ST_MOV_R1, ST_MOV_R2, ST_TEST, ST_ACC, ST_SHR, ST_SHL
  } step_t;

  function automatic logic [4:0] step_op(input step_t s);
    case (s)
      ST_MOV_R1: return OP_MOV_R1;
      ST_MOV_R2: return OP_MOV_R2;
      ST_TEST:   return OP_TEST;
      ST_ACC:    return OP_ACC;
      ST_SHR:    return OP_SHR;
      ST_SHL:    return OP_SHL;
      default:   return OP_MOV_R0;
    endcase
  endfunction

endpackage

// File: rtl/mult_seq.sv
// Sequential multiplier: runs MOV/TEST/ACC/SHR/SHL on an external mult unit
// via a start/done handshake. Define MULT_SEQ_EARLY_EXIT_EN to stop once b is exhausted.
module mult_seq
  import mult_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int ITER    = 16,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] product,
  output logic             m_s,
  output logic [4:0]       m_op,
  output logic [WIDTH-1:0] m_in,
  input  logic             m_done,
  input  logic [WIDTH-1:0] m_out
);

  localparam int IW = $clog2(ITER + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t           state;
  step_t            step;
  step_t            step_nxt;
  logic             fin_nxt;
  logic [WIDTH-1:0] imm_nxt;
  logic [WIDTH-1:0] b_reg;
  logic [IW-1:0]    iter_cnt;
  logic [TW-1:0]    tmo_cnt;
  logic             tmo_hit;
`ifdef MULT_SEQ_EARLY_EXIT_EN
  logic [WIDTH-1:0] shadow;
`endif

  assign tmo_hit = (tmo_cnt == TW'(TIMEOUT - 1));

  // Program sequencer: decides the op after the one that just completed.
  always_comb begin
    step_nxt = step;
    fin_nxt  = 1'b0;
    case (step)
      ST_MOV_R0: step_nxt = ST_MOV_R1;
      ST_MOV_R1: step_nxt = ST_MOV_R2;
      ST_MOV_R2: begin
        step_nxt = ST_TEST;
`ifdef MULT_SEQ_EARLY_EXIT_EN
        if (shadow == '0) fin_nxt = 1'b1;
`endif
      end
      ST_TEST:   step_nxt = ST_ACC;
      ST_ACC:    step_nxt = ST_SHR;
      ST_SHR:    step_nxt = ST_SHL;
      ST_SHL: begin
        step_nxt = ST_TEST;
        fin_nxt  = (iter_cnt == IW'(ITER - 1));
`ifdef MULT_SEQ_EARLY_EXIT_EN
        if (shadow == '0) fin_nxt = 1'b1;
`endif
      end
      default:   step_nxt = ST_MOV_R0;
    endcase
    imm_nxt = (step_nxt == ST_MOV_R1) ? b_reg : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      step     <= ST_MOV_R0;
      b_reg    <= '0;
      iter_cnt <= '0;
      tmo_cnt  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      product  <= '0;
      m_s      <= 1'b0;
      m_op     <= OP_MOV_R0;
      m_in     <= '0;
`ifdef MULT_SEQ_EARLY_EXIT_EN
      shadow   <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          m_s <= 1'b0;
          if (start && m_done) begin
            b_reg    <= b;
            step     <= ST_MOV_R0;
            iter_cnt <= '0;
            err      <= 1'b0;
            busy     <= 1'b1;
            m_s      <= 1'b1;
            m_op     <= OP_MOV_R0;
            m_in     <= a;
            state    <= ISSUE;
`ifdef MULT_SEQ_EARLY_EXIT_EN
            shadow   <= b;
`endif
          end
        end
        ISSUE: begin
          tmo_cnt <= '0;
          state   <= WAIT_LO;
        end
        WAIT_LO: begin
          if (!m_done) begin
            m_s     <= 1'b0;
            tmo_cnt <= '0;
            state   <= WAIT_HI;
          end else if (tmo_hit) begin
            err   <= 1'b1;
            m_s   <= 1'b0;
            busy  <= 1'b0;
            m_op  <= OP_MOV_R0;
            m_in  <= '0;
            state <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        WAIT_HI: begin
          if (m_done) begin
            state <= NEXT;
          end else if (tmo_hit) begin
            err   <= 1'b1;
            m_s   <= 1'b0;
            busy  <= 1'b0;
            m_op  <= OP_MOV_R0;
            m_in  <= '0;
            state <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        NEXT: begin
          step <= step_nxt;
          if (step == ST_SHL) iter_cnt <= iter_cnt + IW'(1);
`ifdef MULT_SEQ_EARLY_EXIT_EN
          if (step == ST_SHR) shadow <= shadow >> 1;
`endif
          if (fin_nxt) begin
            m_op  <= OP_MOV_R0;
            m_in  <= '0;
            state <= FIN;
          end else begin
            m_op  <= step_op(step_nxt);
            m_in  <= imm_nxt;
            m_s   <= 1'b1;
            state <= ISSUE;
          end
        end
        FIN: begin
          product <= m_out;
          done    <= 1'b1;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
